// File: rtl/axis_burst_master_pkg.sv
// Shared definitions for the AXIS burst master/slave pair: FSM state encoding
// and default stream/counter widths.
package axis_burst_master_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_TRANS_WIDTH = 4;

endpackage

// File: rtl/axis_burst_master_burst_buf.sv
// Burst payload buffer: register array with synchronous write and clear,
// combinational read so the master can load the next beat on the same edge.
module burst_buf
    import axis_burst_master_pkg::*;
#(
    parameter int data_width  = DEF_DATA_WIDTH,
    parameter int trans_width = DEF_TRANS_WIDTH,
    parameter int depth       = 2**trans_width
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [trans_width-1:0] wr_addr,
    input  logic [data_width-1:0]  wr_data,
    input  logic [trans_width-1:0] rd_addr,
    output logic [data_width-1:0]  rd_data
);

    logic [data_width-1:0] mem [depth];

    // One register per entry so the whole buffer clears in a single cycle.
    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (clr) begin
                    mem[gi] <= '0;
                end else if (wr_en && (wr_addr == trans_width'(gi))) begin
                    mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Addresses past the last entry only occur on the final beat, where the
    // read value is discarded.
    assign rd_data = (int'(rd_addr) < depth) ? mem[rd_addr] : '0;

endmodule

// File: rtl/axis_burst_master.sv
// AXIS burst master: streams a fixed-length burst from a locally written
// buffer, with zero-bubble beats and stall-safe registered outputs.
module axis_burst_master
    import axis_burst_master_pkg::*;
#(
    parameter int data_width  = DEF_DATA_WIDTH,
    parameter int trans_width = DEF_TRANS_WIDTH,
    parameter int trans_lenth = 2**trans_width
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [trans_width-1:0] wr_addr,
    input  logic [data_width-1:0]  wr_data,
    input  logic                   start,
    output logic [data_width-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [trans_width-1:0] LAST = trans_width'(trans_lenth - 1);
    localparam logic [trans_width-1:0] ONE  = trans_width'(1);

    state_t                  state_reg;
    logic [trans_width-1:0]  cnt_reg;
    logic [trans_width-1:0]  cnt_next;
    logic [trans_width-1:0]  rd_addr;
    logic [data_width-1:0]   rd_data;
    logic                    buf_wr_en;

    // The buffer is locked for the whole burst, and a write that collides
    // with an accepted start is dropped so beat 0 carries the old contents.
    assign buf_wr_en = (state_reg == IDLE) && wr_en && !start;
    assign cnt_next  = cnt_reg + ONE;
    assign rd_addr   = (state_reg == SEND) ? cnt_next : '0;

    burst_buf #(
        .data_width  (data_width),
        .trans_width (trans_width),
        .depth       (trans_lenth)
    ) u_buf (
        .clk     (clk),
        .clr     (rst),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg <= SEND;
                        cnt_reg   <= '0;
                        m_data    <= rd_data;
                        m_valid   <= 1'b1;
                        m_last    <= (LAST == '0);
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    // Without a handshake every output holds its value.
                    if (m_valid && m_ready) begin
                        if (cnt_reg == LAST) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_next;
                            m_data  <= rd_data;
                            m_last  <= (cnt_next == LAST);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_burst_master.sv
// Directed, table-driven bench for axis_burst_master (16-beat bursts of 32-bit data).
module tb_axis_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        busy;
    logic        done;

    axis_burst_master #(
        .data_width  (32),
        .trans_width (4),
        .trans_lenth (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        start;
        logic        wr_en;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_mem [16];
    int          checks = 0;
    int          errors = 0;
    int          hs = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                           input logic l, input logic b, input logic dn);
        chk({tag, ".valid"}, 32'(m_valid), 32'(v));
        chk({tag, ".data"},  m_data, d);
        chk({tag, ".last"},  32'(m_last), 32'(l));
        chk({tag, ".busy"},  32'(busy), 32'(b));
        chk({tag, ".done"},  32'(done), 32'(dn));
    endtask

    // Expected burst seen from the cycle after start: one row per cycle,
    // ready pattern 1,0,0,... in mode 1, then the done row.
    task automatic build(input int mode, input int inject_row, input bit start_at_done);
        int beat = 0;
        int r = 0;
        logic rdy;
        tbl.delete();
        while (beat < 16) begin
            rdy = (mode == 0) ? 1'b1 : ((r % 3) == 0);
            tbl.push_back('{rdy, r == inject_row, r == inject_row,
                            1'b1, exp_mem[beat], beat == 15, 1'b1, 1'b0});
            if (rdy) beat++;
            r++;
        end
        tbl.push_back('{1'b0, start_at_done, 1'b0, 1'b0, exp_mem[15], 1'b0, 1'b0, 1'b1});
    endtask

    task automatic apply(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            chk_out($sformatf("%s[%0d]", tag, i), tbl[i].exp_valid, tbl[i].exp_data,
                    tbl[i].exp_last, tbl[i].exp_busy, tbl[i].exp_done);
            if (m_valid && tbl[i].ready) hs++;
            m_ready = tbl[i].ready;
            start   = tbl[i].start;
            wr_en   = tbl[i].wr_en;
            wr_addr = 4'd3;
            wr_data = 32'hDEAD;
            tick();
        end
        m_ready = 1'b0;
        start   = 1'b0;
        wr_en   = 1'b0;
        $display("burst %s: %0d handshakes so far", tag, hs);
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_buf();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 32'h100 + 32'(i);
            exp_mem[i] = 32'h100 + 32'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Full burst with ready held high.
        fill_buf();
        hs = 0;
        kick();
        build(0, -1, 1'b0);
        apply("ready_high");
        chk("ready_high.hs", 32'(hs), 32'd16);
        chk("ready_high.done_pulse", 32'(done), 32'd0);

        // Same burst with ready toggling 1,0,0.
        hs = 0;
        kick();
        build(1, -1, 1'b0);
        apply("stall");
        chk("stall.hs", 32'(hs), 32'd16);

        // start and write to buf[3] mid-burst are ignored.
        hs = 0;
        kick();
        build(0, 2, 1'b0);
        apply("locked");
        kick();
        build(0, -1, 1'b0);
        apply("locked_after");
        chk("locked.hs", 32'(hs), 32'd32);

        // Reset after beat 7 aborts the burst and clears the buffer.
        kick();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("abort.beat%0d", i), m_data, exp_mem[i]);
            tick();
        end
        m_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("abort.after_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("abort.no_done", 32'(done), 32'd0);
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
        hs = 0;
        kick();
        build(0, -1, 1'b0);
        apply("zeroed");
        chk("zeroed.hs", 32'(hs), 32'd16);

        // Write colliding with start is dropped; start in done cycle chains bursts.
        fill_buf();
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 32'hBEEF;
        hs = 0;
        kick();
        wr_en = 1'b0;
        build(0, -1, 1'b1);
        apply("chain1");
        build(0, -1, 1'b0);
        apply("chain2");
        chk("chain.hs", 32'(hs), 32'd32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_burst_master.md
AXIS_BURST_MASTER -- requirements
Module: axis_burst_master

Interface
REQ-001 The block SHALL have parameter data_width, default 32, giving the stream data width in bits.
REQ-002 The block SHALL have parameter trans_width, default 4, giving the beat-counter and buffer-address width.
REQ-003 The block SHALL have parameter trans_lenth, default 2**trans_width, giving the beats per burst.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port wr_en, input, 1 bit: buffer write strobe.
REQ-007 The block SHALL have port wr_addr, input, trans_width bits: buffer write index.
REQ-008 The block SHALL have port wr_data, input, data_width bits: buffer write data.
REQ-009 The block SHALL have port start, input, 1 bit: burst request.
REQ-010 The block SHALL have port m_data, output, data_width bits: AXIS master data.
REQ-011 The block SHALL have port m_valid, output, 1 bit: AXIS master valid.
REQ-012 The block SHALL have port m_ready, input, 1 bit: AXIS downstream ready.
REQ-013 The block SHALL have port m_last, output, 1 bit: final beat of the burst.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the block is in SEND.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse on burst completion.

Function
REQ-016 The block SHALL implement a state machine with two states: IDLE and SEND.
REQ-017 In IDLE with wr_en=1 and start=0, the block SHALL write wr_data to buffer entry wr_addr at the clock edge.
REQ-018 In IDLE with start=1, the block SHALL, at the same edge, enter SEND with cnt=0, m_valid=1 and m_data=buf[0]; m_valid SHALL be visible one cycle after start.
REQ-019 The block SHALL drop wr_en when it coincides with an accepted start, and SHALL ignore wr_en throughout SEND, so the buffer is locked.
REQ-020 The block SHALL ignore start while in SEND.
REQ-021 A handshake SHALL be defined as m_valid=1 and m_ready=1 at a clock edge.
REQ-022 On a handshake with cnt<trans_lenth-1, the block SHALL set cnt<=cnt+1, m_data<=buf[cnt+1] and keep m_valid=1, giving zero-bubble back-to-back beats.
REQ-023 While m_valid=1 and m_ready=0, the block SHALL hold m_data, m_valid, m_last and cnt stable; m_valid SHALL never drop before the handshake.
REQ-024 The block SHALL assert m_last exactly when m_valid=1 and cnt=trans_lenth-1.
REQ-025 On the handshake at cnt=trans_lenth-1, the block SHALL set m_valid<=0, m_last<=0, cnt<=0, state<=IDLE and done<=1 for exactly one cycle.
REQ-026 The block SHALL drive busy=1 exactly while in SEND.
REQ-027 The block SHALL accept a start in the cycle done=1, beginning a new burst with no dead cycle beyond the one IDLE cycle.
REQ-028 cnt SHALL be trans_width bits and SHALL never exceed trans_lenth-1; beats per burst SHALL always equal trans_lenth.
REQ-029 m_data SHALL be don't-care-free: it holds its last value while m_valid=0.

Reset
REQ-030 With rst=1 at an edge, the block SHALL set state=IDLE, cnt=0, m_valid=0, m_last=0, m_data=0, done=0, busy=0, and clear all buffer entries to 0.
REQ-031 A reset mid-burst SHALL abort the burst immediately, with no done pulse and m_valid low in the next cycle.

Structure
REQ-032 The state encodings IDLE/SEND and the default widths SHALL be defined in a shared package shared with the AXIS slave.
REQ-033 The buffer SHALL be a separate sub-module, burst_buf (trans_lenth x data_width; synchronous write, combinational read, synchronous clear); the FSM, counter and output registers SHALL stay in the top level.

Verification
REQ-034 The bench SHALL cover: write buf[i]=0x100+i for i=0..15, start, m_ready held 1 -> 16 consecutive beats 0x100..0x10F, m_last only on 0x10F, done pulse the cycle after, busy high for 16 cycles.
REQ-035 The bench SHALL cover: the same burst with m_ready toggling 1,0,0,1,... -> data and m_last held across stalls, no beat lost or duplicated, exactly 16 handshakes.
REQ-036 The bench SHALL cover: start pulsed during SEND and wr_en (addr 3, data 0xDEAD) during SEND -> no restart, and the next burst still sends the original buf[3].
REQ-037 The bench SHALL cover: rst=1 after beat 7 -> m_valid=0 next cycle, no done pulse, and a following burst reads all-zero data.
REQ-038 The bench SHALL cover: start asserted in the done cycle -> second burst's first beat valid one cycle later, 32 handshakes total.
REQ-039 The bench SHALL cover: start and wr_en(addr 0, 0xBEEF) in the same IDLE cycle -> first beat carries the old buf[0] and the write is dropped.
